// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the RV32I multicycle core's memory port.
// It accepts one read or write per transaction, pulses mem_resp LATENCY cycles
// after acceptance, and serves a word-organised on-chip array with byte-enable
// writes. Out-of-window requests and simultaneous read+write flag err.
module mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h4000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;

    // Latched transaction
    logic            rd_q;       // read op (including illegal read+write)
    logic            rd_ok_q;    // legal, in-range read
    logic            wr_ok_q;    // legal, in-range write
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     rdata_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Request decode; 32-bit unsigned wrap makes addresses below the base land out of range
    logic [31:0]     offset;
    logic            in_range;
    logic [AW-1:0]   req_idx;
    logic            both;
    logic            unused_offset;

    assign offset        = mem_address - ADDR_BASE;
    assign in_range      = (offset[31:AW+2] == '0);
    assign req_idx       = offset[AW+1:2];
    assign both          = mem_read & mem_write;
    assign unused_offset = ^offset[1:0];

    // With LATENCY==1 the read happens on the accept edge, so source from the live request
    logic            src_rd;
    logic            src_rd_ok;
    logic [AW-1:0]   src_idx;
    logic            enter_resp;

    assign src_rd     = (state_q == StIdle) ? mem_read : rd_q;
    assign src_rd_ok  = (state_q == StIdle) ? (mem_read & ~mem_write & in_range) : rd_ok_q;
    assign src_idx    = (state_q == StIdle) ? req_idx : idx_q;
    assign enter_resp = (state_d == StResp) && (state_q != StResp);

    // Next-state and latency counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_read | mem_write) begin
                    accept  = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, counter, transaction latch and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            rd_ok_q <= 1'b0;
            wr_ok_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q    <= mem_read;
                rd_ok_q <= mem_read & ~mem_write & in_range;
                wr_ok_q <= mem_write & ~mem_read & in_range;
                err_q   <= both | ~in_range;
            end
            if (enter_resp && src_rd) begin
                rdata_q <= src_rd_ok ? mem_q[src_idx] : 32'h0;
            end
        end
    end

    // Datapath latch; only meaningful after an accept, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
        end
    end

    // Array write commits on the edge ending RESP; reset in RESP cancels it
    always_ff @(posedge clk) begin
        if (!rst && state_q == StResp && wr_ok_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_resp  = (state_q == StResp);
    assign err       = mem_resp & err_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance a (LATENCY=3, 1024 words) and
// instance b (LATENCY=1, 16 words) share clock and reset.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_read, a_write, a_resp, a_err;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_read, b_write, b_resp, b_err;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_BASE  (32'h4000_0000),
        .DEPTH_WORDS(1024),
        .LATENCY    (3)
    ) u_a (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (a_read),
        .mem_write      (a_write),
        .mem_byte_enable(a_be),
        .mem_address    (a_addr),
        .mem_wdata      (a_wdata),
        .mem_rdata      (a_rdata),
        .mem_resp       (a_resp),
        .err            (a_err)
    );

    mem_responder #(
        .ADDR_BASE  (32'h4000_0000),
        .DEPTH_WORDS(16),
        .LATENCY    (1)
    ) u_b (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (b_read),
        .mem_write      (b_write),
        .mem_byte_enable(b_be),
        .mem_address    (b_addr),
        .mem_wdata      (b_wdata),
        .mem_rdata      (b_rdata),
        .mem_resp       (b_resp),
        .err            (b_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        if (sel) begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd; b_be = be;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
        end
    endtask

    function automatic logic resp_of(input bit sel);
        return sel ? b_resp : a_resp;
    endfunction

    function automatic logic err_of(input bit sel);
        return sel ? b_err : a_err;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? b_rdata : a_rdata;
    endfunction

    // Cycles until mem_resp is seen (0 if the bound expires)
    task automatic wait_resp(input bit sel, input int bound, output int lat);
        lat = 0;
        for (int k = 1; k <= bound; k++) begin
            cyc();
            if (resp_of(sel)) begin
                lat = k;
                break;
            end
        end
    endtask

    // One full transaction: request held until mem_resp, then dropped
    task automatic txn(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                       input int exp_lat, input logic exp_err,
                       input bit chk_rd, input logic [31:0] exp_rdata, input string tag);
        int lat;
        drive(sel, rd, wr, addr, wd, be);
        wait_resp(sel, 20, lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " err"}, 32'(err_of(sel)), 32'(exp_err));
        if (chk_rd) chk({tag, " rdata"}, rdata_of(sel), exp_rdata);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        chk({tag, " one-cycle pulse"}, 32'(resp_of(sel)), 32'h0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) cyc();
        chk("reset a resp", 32'(a_resp), 32'h0);
        chk("reset a err", 32'(a_err), 32'h0);
        chk("reset a rdata", a_rdata, 32'h0);
        chk("reset b resp", 32'(b_resp), 32'h0);
        chk("reset b rdata", b_rdata, 32'h0);
        rst = 1'b0;
        cyc();

        // Read latency with word 0 = DEAD_BEEF
        txn(0, 0, 1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 32'h0, "wr w0");
        txn(0, 1, 0, 32'h4000_0000, 32'h0, 4'h0, 3, 0, 1, 32'hDEAD_BEEF, "rd w0");

        // Byte-enable merge
        txn(0, 0, 1, 32'h4000_0010, 32'h1122_3344, 4'hF, 3, 0, 0, 32'h0, "wr full");
        txn(0, 0, 1, 32'h4000_0010, 32'hAABB_CCDD, 4'b0101, 3, 0, 0, 32'h0, "wr be0101");
        txn(0, 1, 0, 32'h4000_0010, 32'h0, 4'h0, 3, 0, 1, 32'h11BB_33DD, "rd merged");

        // Window boundaries
        txn(0, 0, 1, 32'h4000_0FFC, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 32'h0, "wr last");
        txn(0, 1, 0, 32'h4000_0FFC, 32'h0, 4'h0, 3, 0, 1, 32'hCAFE_F00D, "rd last");
        txn(0, 1, 0, 32'h4000_1000, 32'h0, 4'h0, 3, 1, 1, 32'h0, "rd past end");
        txn(0, 0, 1, 32'h3FFF_FFFC, 32'h1234_5678, 4'hF, 3, 1, 0, 32'h0, "wr below base");
        txn(0, 1, 0, 32'h4000_0FFC, 32'h0, 4'h0, 3, 0, 1, 32'hCAFE_F00D, "rd last again");

        // Empty byte mask: legal, no change, rdata holds across a write
        txn(0, 0, 1, 32'h4000_0000, 32'h0BAD_0BAD, 4'h0, 3, 0, 1, 32'hCAFE_F00D, "wr be0");
        txn(0, 1, 0, 32'h4000_0000, 32'h0, 4'h0, 3, 0, 1, 32'hDEAD_BEEF, "rd after be0");

        // Illegal read+write, then held read re-accepted in the gap cycle
        drive(0, 1, 1, 32'h4000_0010, 32'hFFFF_FFFF, 4'hF);
        wait_resp(0, 20, lat);
        chk("illegal latency", 32'(lat), 32'd3);
        chk("illegal rdata", a_rdata, 32'h0);
        chk("illegal err", 32'(a_err), 32'h1);
        drive(0, 1, 0, 32'h4000_0010, 32'h0, 4'h0);
        wait_resp(0, 20, lat);
        chk("back-to-back spacing", 32'(lat), 32'd4);
        chk("back-to-back rdata", a_rdata, 32'h11BB_33DD);
        chk("back-to-back err", 32'(a_err), 32'h0);
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        cyc();

        // Reset during WAIT cancels the write
        txn(0, 0, 1, 32'h4000_0020, 32'h0, 4'hF, 3, 0, 0, 32'h0, "wr zero");
        drive(0, 0, 1, 32'h4000_0020, 32'h5555_5555, 4'hF);
        cyc();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        cyc();
        rst = 1'b0;
        wait_resp(0, 8, lat);
        chk("rst wait no resp", 32'(lat), 32'd0);
        chk("rst wait rdata", a_rdata, 32'h0);
        txn(0, 1, 0, 32'h4000_0020, 32'h0, 4'h0, 3, 0, 1, 32'h0, "rd after rst wait");

        // Reset in the RESP cycle also cancels the write
        drive(0, 0, 1, 32'h4000_0020, 32'h5555_5555, 4'hF);
        wait_resp(0, 20, lat);
        chk("rst resp latency", 32'(lat), 32'd3);
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        cyc();
        rst = 1'b0;
        chk("rst resp cleared", 32'(a_resp), 32'h0);
        txn(0, 1, 0, 32'h4000_0020, 32'h0, 4'h0, 3, 0, 1, 32'h0, "rd after rst resp");

        // LATENCY=1 instance
        txn(1, 0, 1, 32'h4000_0000, 32'h0000_1234, 4'hF, 1, 0, 0, 32'h0, "b wr");
        drive(1, 1, 0, 32'h4000_0000, 32'h0, 4'h0);
        wait_resp(1, 20, lat);
        chk("b rd latency", 32'(lat), 32'd1);
        chk("b rd rdata", b_rdata, 32'h0000_1234);
        wait_resp(1, 20, lat);
        chk("b held spacing", 32'(lat), 32'd2);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
        cyc();
        txn(1, 1, 0, 32'h4000_0040, 32'h0, 4'h0, 1, 1, 1, 32'h0, "b rd past end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
